mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
Sequential signed multiply/divide engine serving MULT and DIV in the multicycle CPU.
- Consumes MultStart/DivStart and operands A/B from the register-read latches.
- Returns mult_done/div_done plus 64-bit {hi_out, lo_out}, which the control FSM loads into HI/LO in the done cycle.
- One operation in flight at a time.
- Multiply is radix-2 Booth; divide is restoring on magnitudes, followed by sign fix-up.

Parameters:
- WIDTH, 32, operand width. The iteration count equals WIDTH; hi_out and lo_out are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- mult_start  input  1  start signed multiply; sampled only in IDLE.
- div_start  input  1  start signed divide; sampled only in IDLE.
- a  input  WIDTH  multiplicand / dividend; captured on the accepting edge.
- b  input  WIDTH  multiplier / divisor; captured on the accepting edge.
- hi_out  output  WIDTH  product[63:32] or remainder.
- lo_out  output  WIDTH  product[31:0] or quotient.
- mult_done  output  1  one-cycle pulse; multiply result valid.
- div_done  output  1  one-cycle pulse; divide result valid.
- div_zero  output  1  set with div_done when divisor was 0; held until next accepted start.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE.
  - hi_out=0, lo_out=0, mult_done=0, div_done=0, div_zero=0, busy=0.
  - All internal accumulators and counters are cleared.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE, MULT, DIV, DIV_FIX, DONE.
- IDLE:
  - Accepting edge T: mult_start=1 -> MULT; else div_start=1 -> DIV. If both are high, multiply wins and div_start is dropped.
  - a and b are captured and the counter is loaded with WIDTH. div_zero clears.
  - Starts in any non-IDLE state are ignored; no queueing.
- MULT:
  - Booth on {acc[2W], q[W], q_-1}; one iteration per cycle.
  - Per iteration: pair 01 -> add a, 10 -> subtract a, then arithmetic right shift.
  - Cycles T+1..T+32, then DONE.
  - mult_done=1 in cycle T+33 with the full signed 64-bit product.
- DIV:
  - If b==0 at acceptance, go directly to DONE: done in cycle T+1, hi_out=a, lo_out=0, div_zero=1.
  - Otherwise run restoring division on |a|, |b|: shift, trial subtract, restore if negative, one quotient bit per cycle.
  - Cycles T+1..T+32, then DIV_FIX (cycle T+33).
- DIV_FIX:
  - Quotient is negated iff sign(a)!=sign(b).
  - Remainder takes the sign of a; truncation is toward zero (MIPS semantics).
  - Next state DONE; div_done=1 in cycle T+34.
- Overflow cases:
  - a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, div_zero=0, no trap.
  - |0x80000000| must be handled as the unsigned value 2^31; a 33-bit magnitude path is required.
- DONE:
  - Exactly one of mult_done/div_done is high for one cycle; busy=1.
  - Next state is IDLE unconditionally.
  - hi_out/lo_out are stable from the DONE cycle until the next accepted start. Outputs are registered and do not change during iterations.
  - A new start is accepted at the earliest on the edge ending the first IDLE cycle after DONE.
- Arithmetic and timing rules:
  - All arithmetic is two's complement modulo 2^64 for products; no saturation.
  - Latency is fixed and data-independent: mult 33 cycles, div 34 cycles (b!=0) or 1 cycle (b==0).

Test Plan:
- Reset low for 2 cycles mid-MULT (cycle T+10), then high -> no mult_done ever pulses; hi_out=lo_out=0; busy=0; a fresh mult_start is accepted on the next edge.
- mult_start, a=0xFFFFFFFD (-3), b=7 -> mult_done exactly in cycle T+33, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; a=b=0x80000000 -> hi_out=0x40000000, lo_out=0.
- div_start, a=-7 (0xFFFFFFF9), b=2 -> div_done in T+34, lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1), div_zero=0; a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
- div_start, a=0x12345678, b=0 -> div_done in T+1, div_zero=1, hi_out=0x12345678, lo_out=0; a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- mult_start and div_start both high in IDLE -> multiply executes, only mult_done pulses; div_start pulsed at T+5 while busy -> ignored, no second done.
- Back-to-back: mult_start held high continuously -> second operation accepted on the first IDLE cycle after DONE; done pulses exactly 34 cycles apart; hi/lo hold the previous result until the second done.

Source files
------------

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide engine for the multicycle CPU.
// Multiply: radix-2 Booth, one iteration per cycle, WIDTH iterations.
// Divide: restoring division on operand magnitudes, then a sign fix-up cycle.
// Results are registered into hi_out/lo_out only on the edge entering DONE,
// so they hold the previous result for the whole duration of an operation.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for mult_start/div_start, outputs hold last result
// MULT    | Booth iterations on {acc, q, q_m1}
// DIV     | restoring-division iterations on |a| / |b|
// DIV_FIX | apply quotient/remainder signs, load hi_out/lo_out
// DONE    | one-cycle done pulse, then back to IDLE
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             mult_done,
  output logic             div_done,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    DIV_FIX,
    DONE
  } state_t;

  state_t state;

  // acc is one bit wider than an operand so that Booth can subtract
  // -2^(WIDTH-1) and the divider can hold a shifted partial remainder.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH:0]   m_reg;
  logic [CW-1:0]    cnt;
  logic             a_neg;
  logic             b_neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_acc_nx;
  logic [WIDTH-1:0] booth_q_nx;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic             div_ok;
  logic [WIDTH:0]   div_rem_nx;
  logic [WIDTH-1:0] div_q_nx;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes; the most negative value maps to the unsigned 2^(WIDTH-1).
  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
  end

  // One Booth step: add/subtract multiplicand per bit pair, then arithmetic shift.
  always_comb begin
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + m_reg;
      2'b10:   booth_sum = acc - m_reg;
      default: booth_sum = acc;
    endcase
    booth_acc_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q_nx   = {booth_sum[0], q[WIDTH-1:1]};
  end

  // One restoring-division step: shift in the next dividend bit, trial subtract.
  always_comb begin
    div_shift  = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_trial  = {1'b0, div_shift} - {1'b0, m_reg};
    div_ok     = ~div_trial[WIDTH+1];
    div_rem_nx = div_ok ? div_trial[WIDTH:0] : div_shift;
    div_q_nx   = {q[WIDTH-2:0], div_ok};
  end

  // Sign fix-up: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    quot_fix = (a_neg ^ b_neg) ? -q : q;
    rem_fix  = a_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      q         <= '0;
      q_m1      <= 1'b0;
      m_reg     <= '0;
      cnt       <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      mult_done <= 1'b0;
      div_done  <= 1'b0;
      div_zero  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mult_done <= 1'b0;
          div_done  <= 1'b0;
          if (mult_start) begin
            state    <= MULT;
            acc      <= '0;
            q        <= b;
            q_m1     <= 1'b0;
            m_reg    <= {a[WIDTH-1], a};
            cnt      <= CW'(WIDTH);
            div_zero <= 1'b0;
            busy     <= 1'b1;
          end else if (div_start) begin
            a_neg <= a[WIDTH-1];
            b_neg <= b[WIDTH-1];
            busy  <= 1'b1;
            if (b == '0) begin
              // Divide by zero short-circuits straight to the done cycle.
              state    <= DONE;
              hi_out   <= a;
              lo_out   <= '0;
              div_zero <= 1'b1;
              div_done <= 1'b1;
            end else begin
              state    <= DIV;
              acc      <= '0;
              q        <= a_mag;
              q_m1     <= 1'b0;
              m_reg    <= {1'b0, b_mag};
              cnt      <= CW'(WIDTH);
              div_zero <= 1'b0;
            end
          end
        end
        MULT: begin
          acc  <= booth_acc_nx;
          q    <= booth_q_nx;
          q_m1 <= q[0];
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            hi_out    <= booth_acc_nx[WIDTH-1:0];
            lo_out    <= booth_q_nx;
            mult_done <= 1'b1;
          end
        end
        DIV: begin
          acc <= div_rem_nx;
          q   <= div_q_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          state    <= DONE;
          hi_out   <= rem_fix;
          lo_out   <= quot_fix;
          div_done <= 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          mult_done <= 1'b0;
          div_done  <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
